// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared word/fetch-entry types and queue size defaults
package instr_queue_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam int IQ_DEPTH       = 8;
  localparam int IQ_FETCH_WIDTH = 2;
  localparam int IQ_ISSUE_WIDTH = 2;

  // Smaller of two unsigned quantities; used to clamp pop requests.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch/decode side signals of the instruction queue
interface instr_queue_if
  import instr_queue_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int FETCH_WIDTH = IQ_FETCH_WIDTH,
  parameter int ISSUE_WIDTH = IQ_ISSUE_WIDTH
) ();

  logic [FETCH_WIDTH-1:0]               in_valid;
  fetch_entry_t [FETCH_WIDTH-1:0]       in_entry;
  logic                                 in_ready;
  logic [ISSUE_WIDTH-1:0]               out_valid;
  fetch_entry_t [ISSUE_WIDTH-1:0]       out_entry;
  logic [$clog2(ISSUE_WIDTH+1)-1:0]     pop_count;
  logic                                 flush;
  logic [$clog2(DEPTH):0]               count;

  modport master (
    output in_valid, in_entry, pop_count, flush,
    input  in_ready, out_valid, out_entry, count
  );

  modport slave (
    input  in_valid, in_entry, pop_count, flush,
    output in_ready, out_valid, out_entry, count
  );

endinterface

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - circular instruction queue between fetch and decode
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH       = IQ_DEPTH,
  parameter int FETCH_WIDTH = IQ_FETCH_WIDTH,
  parameter int ISSUE_WIDTH = IQ_ISSUE_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  instr_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            ready;
  logic            push_en;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   avail;
  logic [CW-1:0]   pop_n;

  // Ready looks only at registered occupancy so pop_count never reaches in_ready.
  assign ready = (count_q <= CW'(DEPTH - FETCH_WIDTH));

  // Push/pop amounts: pushes are all-or-nothing, pops clamp to what is visible.
  always_comb begin
    push_n = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      push_n = push_n + CW'(q.in_valid[i]);
    end
    if (!ready) begin
      push_n = '0;
    end
    push_en = ready && (|q.in_valid) && !q.flush;
    avail   = CW'(min_u(int'(count_q), ISSUE_WIDTH));
    pop_n   = CW'(min_u(int'(q.pop_count), int'(avail)));
  end

  // Next pointer/count; flush wins over any same-cycle push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(pop_n);
      tail_d  = tail_q + PW'(push_n);
      count_d = count_q + push_n - pop_n;
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage: written in lane order at the tail, never reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (q.in_valid[i]) begin
          mem_q[tail_q + PW'(i)] <= q.in_entry[i];
        end
      end
    end
  end

  // Head read mux: lane i shows the entry i places behind the head.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      q.out_valid[i] = (count_q > CW'(i));
      q.out_entry[i] = mem_q[head_q + PW'(i)];
    end
  end

  assign q.in_ready = ready;
  assign q.count    = count_q;

  // Decode must never consume more entries than it was shown.
  pop_legal: assert property (@(posedge clk) disable iff (reset)
    CW'(q.pop_count) <= avail);

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - self-checking bench for instr_queue
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int IW    = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instr_queue_if #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) iq ();

  instr_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (iq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a plain FIFO of entries, updated by the queue's rules.
  fetch_entry_t mq[$];

  always @(posedge clk or posedge reset) begin
    if (reset || iq.flush) begin
      mq.delete();
    end else begin
      int sz;
      int npush;
      int npop;
      sz    = mq.size();
      npush = 0;
      for (int i = 0; i < FW; i++) npush += int'(iq.in_valid[i]);
      npop = int'(iq.pop_count);
      if (npop > sz) npop = sz;
      if (npop > IW) npop = IW;
      for (int i = 0; i < npop; i++) void'(mq.pop_front());
      if ((DEPTH - sz) >= FW) begin
        for (int i = 0; i < npush; i++) mq.push_back(iq.in_entry[i]);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference FIFO.
  always @(negedge clk) begin
    if (!reset) begin
      check("model_count", longint'(iq.count), longint'(mq.size()));
      check("model_in_ready", longint'(iq.in_ready), longint'((DEPTH - mq.size()) >= FW));
      for (int i = 0; i < IW; i++) begin
        check("model_out_valid", longint'(iq.out_valid[i]), longint'(mq.size() > i));
        if (mq.size() > i) begin
          check("model_pc", longint'(iq.out_entry[i].pc), longint'(mq[i].pc));
          check("model_instr", longint'(iq.out_entry[i].instr), longint'(mq[i].instr));
        end
      end
    end
  end

  task automatic drive(input logic [1:0] v, input word_t pc0, input logic [1:0] pop, input logic fl);
    iq.in_valid          = v;
    iq.in_entry[0].pc    = pc0;
    iq.in_entry[0].instr = pc0 ^ 32'h5A5A_0000;
    iq.in_entry[1].pc    = pc0 + 32'd4;
    iq.in_entry[1].instr = (pc0 + 32'd4) ^ 32'h5A5A_0000;
    iq.pop_count         = pop;
    iq.flush             = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  word_t pc;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(2'b00, 32'h0, 2'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("reset_count", longint'(iq.count), 0);
    check("reset_out_valid", longint'(iq.out_valid), 0);
    check("reset_in_ready", longint'(iq.in_ready), 1);

    // First bundle after reset.
    drive(2'b11, 32'h8000_0000, 2'd0, 1'b0);
    tick();
    check("first_count", longint'(iq.count), 2);
    check("first_out_valid", longint'(iq.out_valid), 3);
    check("first_pc0", longint'(iq.out_entry[0].pc), 64'h8000_0000);
    check("first_pc1", longint'(iq.out_entry[1].pc), 64'h8000_0004);

    // Fill to DEPTH, then a push into the full queue is ignored.
    pc = 32'h8000_0008;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, pc, 2'd0, 1'b0);
      tick();
      pc += 32'd8;
    end
    check("full_count", longint'(iq.count), 8);
    check("full_in_ready", longint'(iq.in_ready), 0);
    drive(2'b11, 32'hDEAD_0000, 2'd0, 1'b0);
    tick();
    check("full_hold_count", longint'(iq.count), 8);
    check("full_hold_pc0", longint'(iq.out_entry[0].pc), 64'h8000_0000);

    // Full queue refuses a push even while popping.
    drive(2'b11, 32'hDEAD_0100, 2'd1, 1'b0);
    tick();
    check("full_pop_count", longint'(iq.count), 7);
    check("seven_in_ready", longint'(iq.in_ready), 0);
    drive(2'b11, 32'hDEAD_0200, 2'd0, 1'b0);
    tick();
    check("seven_block", longint'(iq.count), 7);
    drive(2'b00, 32'h0, 2'd1, 1'b0);
    tick();
    check("six_count", longint'(iq.count), 6);
    check("six_in_ready", longint'(iq.in_ready), 1);

    // Simultaneous push 2 / pop 2, then a long wrap run.
    pc = 32'h8000_0100;
    drive(2'b11, pc, 2'd2, 1'b0);
    tick();
    pc += 32'd8;
    check("pushpop_count", longint'(iq.count), 6);
    check("pushpop_pc0", longint'(iq.out_entry[0].pc), 64'h8000_0010);
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, pc, 2'd2, 1'b0);
      tick();
      pc += 32'd8;
    end
    check("wrap_count", longint'(iq.count), 6);
    check("wrap_pc0", longint'(iq.out_entry[0].pc), 64'h8000_0100 + 64'd8 * 18);

    // Flush with a same-cycle push.
    drive(2'b00, 32'h0, 2'd1, 1'b0);
    tick();
    check("five_count", longint'(iq.count), 5);
    drive(2'b11, 32'hDEAD_0300, 2'd0, 1'b1);
    tick();
    check("flush_count", longint'(iq.count), 0);
    check("flush_out_valid", longint'(iq.out_valid), 0);
    drive(2'b11, 32'h9000_0000, 2'd0, 1'b0);
    tick();
    check("post_flush_pc0", longint'(iq.out_entry[0].pc), 64'h9000_0000);
    check("post_flush_count", longint'(iq.count), 2);

    // Asynchronous reset in the middle of a cycle at count 4.
    drive(2'b11, 32'h9000_0008, 2'd0, 1'b0);
    tick();
    drive(2'b00, 32'h0, 2'd0, 1'b0);
    check("pre_reset_count", longint'(iq.count), 4);
    #2;
    reset = 1'b1;
    #1;
    check("async_count", longint'(iq.count), 0);
    check("async_out_valid", longint'(iq.out_valid), 0);
    check("async_in_ready", longint'(iq.in_ready), 1);
    tick();
    reset = 1'b0;

    // Single-lane push right after reset release.
    drive(2'b01, 32'hA000_0000, 2'd0, 1'b0);
    tick();
    check("single_count", longint'(iq.count), 1);
    check("single_out_valid", longint'(iq.out_valid), 1);
    check("single_pc0", longint'(iq.out_entry[0].pc), 64'hA000_0000);
    drive(2'b00, 32'h0, 2'd1, 1'b0);
    tick();
    check("drain_count", longint'(iq.count), 0);
    drive(2'b00, 32'h0, 2'd0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of queue entries; it must be a power of two and at least 4.
REQ-002 The block SHALL have parameter FETCH_WIDTH, default 2, meaning the maximum instructions pushed per cycle (1 or 2).
REQ-003 The block SHALL have parameter ISSUE_WIDTH, default 2, meaning the maximum instructions presented and popped per cycle (1 or 2).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, FETCH_WIDTH bits, the lane-valid mask of the fetch bundle; it must be contiguous from lane 0.
REQ-007 The block SHALL have port in_entry, input, FETCH_WIDTH x fetch_entry_t, the per-lane pc and instr.
REQ-008 The block SHALL have port in_ready, output, 1 bit, high when the number of free entries is at least FETCH_WIDTH.
REQ-009 The block SHALL have port out_valid, output, ISSUE_WIDTH bits, the contiguous mask of valid head entries.
REQ-010 The block SHALL have port out_entry, output, ISSUE_WIDTH x fetch_entry_t; lane 0 is the oldest entry.
REQ-011 The block SHALL have port pop_count, input, clog2(ISSUE_WIDTH+1) bits, the number of head entries consumed by decode this cycle.
REQ-012 The block SHALL have port flush, input, 1 bit, which discards all contents (branch mispredict or exception redirect).
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits, the current occupancy.

Function
REQ-014 A push SHALL occur when in_ready and any in_valid bit are high; it writes popcount(in_valid) entries at the tail in lane order, all or nothing.
REQ-015 in_ready SHALL depend only on registered occupancy; the same-cycle pop_count gives no credit, so there is no combinational path from pop_count to in_ready.
REQ-016 out_valid[i] SHALL equal (count > i), and out_entry SHALL be read combinationally from storage at head+i modulo DEPTH.
REQ-017 Push-to-out_valid latency SHALL be one cycle; there is no same-cycle bypass.
REQ-018 pop_count greater than popcount(out_valid) is illegal; the design SHALL saturate the pop to count, and a simulation assertion SHALL flag the violation.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH; next count = count + pushed - popped in one cycle.
REQ-020 A simultaneous push and pop SHALL both take effect in the same cycle.
REQ-021 A full queue (count = DEPTH) SHALL accept no push even if pop_count is nonzero.
REQ-022 An empty queue SHALL drive out_valid all zero; out_entry is don't-care.
REQ-023 flush SHALL have priority: next head = tail = count = 0, and same-cycle pushes and pops are discarded.
REQ-024 Storage payload SHALL NOT need to be reset; only pointers and count are reset.

Reset
REQ-025 On reset assertion the block SHALL asynchronously force head = 0, tail = 0, count = 0, out_valid = 0, and in_ready = 1.
REQ-026 After reset release the first push SHALL be accepted on the first rising edge; reset mid-operation discards all contents exactly as flush does.

Structure
REQ-027 fetch_entry_t {word_t pc; word_t instr;} SHALL be declared in the shared mips package, next to word_t.
REQ-028 DEPTH, FETCH_WIDTH and ISSUE_WIDTH defaults SHALL be package constants so the datapath and hazard logic share them.
REQ-029 The block SHALL be flat with no sub-module; the pointer/count update and the head read mux are kept in separate always blocks.
REQ-030 The block SHALL sit between the fetch stage and decode, replacing the single Dreg, and hazard stall maps to pop_count = 0.

Verification
REQ-031 After reset, push in_valid=2'b11 with pc 0x80000000/0x80000004 -> next cycle count=2, out_valid=2'b11, lane 0 pc=0x80000000.
REQ-032 Push 2 per cycle with pop_count=0 for 4 cycles at DEPTH=8 -> count=8, in_ready=0; a further push is ignored and count stays 8.
REQ-033 At count=7, push 2'b11 -> in_ready=0 blocks the push; at count=6 with pop_count=2 and a 2-lane push -> next count=6.
REQ-034 Wrap test: 20 cycles of push 2 and pop 2 -> pcs emerge strictly in order with no loss or duplication across the pointer wrap.
REQ-035 At count=5, flush plus a push of 2'b11 -> next count=0, out_valid=0; the following push appears with its own pc.
REQ-036 Assert reset asynchronously mid-cycle at count=4 -> out_valid=0 and count=0 immediately, before the next clock edge.
